// File: rtl/out_buff_pkg.sv
//------------------------------------------------------------------------------
// Module  : out_buff_pkg
// Brief   : Shared widths, FSM state type, tile configuration record and the
//           output saturation helper for the output-buffer write stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package out_buff_pkg;

  localparam int NUM_PE_ROW  = 16;
  localparam int IN_WIDTH    = 24;
  localparam int OUT_WIDTH   = 16;
  localparam int NB_DATA     = 8192;
  localparam int ADDR_WIDTH  = $clog2(NB_DATA);
  localparam int LEN_WIDTH   = ADDR_WIDTH + 1;
  localparam int SHIFT_WIDTH = 4;

  localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'(32767);
  localparam logic signed [IN_WIDTH:0] SAT_MIN = -(IN_WIDTH+1)'(32768);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } orw_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [LEN_WIDTH-1:0]   tile_len;
    logic [SHIFT_WIDTH-1:0] shift_amt;
    logic [NUM_PE_ROW-1:0]  row_en;
  } tile_cfg_t;

  function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [IN_WIDTH:0] v);
    if (v > SAT_MAX)      return 16'sh7FFF;
    else if (v < SAT_MIN) return 16'sh8000;
    else                  return $signed(v[OUT_WIDTH-1:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/out_requant_writer_if.sv
//------------------------------------------------------------------------------
// Module  : out_requant_writer_if
// Brief   : Tile control, PE-array beat and buffer write signals of the
//           requantizing output writer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface out_requant_writer_if;
  import out_buff_pkg::*;

  logic                             start_i;
  logic [ADDR_WIDTH-1:0]            base_addr_i;
  logic [LEN_WIDTH-1:0]             tile_len_i;
  logic [SHIFT_WIDTH-1:0]           shift_amt_i;
  logic [NUM_PE_ROW-1:0]            row_en_i;
  logic [NUM_PE_ROW*IN_WIDTH-1:0]   array_out_even_i;
  logic [NUM_PE_ROW*IN_WIDTH-1:0]   array_out_odd_i;
  logic                             array_valid_i;
  logic [NUM_PE_ROW*OUT_WIDTH-1:0]  wdata_even_o;
  logic [NUM_PE_ROW*OUT_WIDTH-1:0]  wdata_odd_o;
  logic [NUM_PE_ROW-1:0]            wen_even_AH_o;
  logic [NUM_PE_ROW-1:0]            wen_odd_AH_o;
  logic [NUM_PE_ROW*ADDR_WIDTH-1:0] waddr_o;
  logic                             busy_o;
  logic                             tile_done_o;
  logic                             err_drop_o;

  modport slave (
    input  start_i, base_addr_i, tile_len_i, shift_amt_i, row_en_i,
    input  array_out_even_i, array_out_odd_i, array_valid_i,
    output wdata_even_o, wdata_odd_o, wen_even_AH_o, wen_odd_AH_o, waddr_o,
    output busy_o, tile_done_o, err_drop_o
  );

  modport master (
    output start_i, base_addr_i, tile_len_i, shift_amt_i, row_en_i,
    output array_out_even_i, array_out_odd_i, array_valid_i,
    input  wdata_even_o, wdata_odd_o, wen_even_AH_o, wen_odd_AH_o, waddr_o,
    input  busy_o, tile_done_o, err_drop_o
  );

endinterface

`default_nettype wire

// File: rtl/out_requant_writer_lane.sv
//------------------------------------------------------------------------------
// Module  : requant_lane
// Brief   : One 24->16 bit requantization lane: S1 round + arithmetic shift,
//           S2 saturate (negative clamp when OUT_REQUANT_RELU_EN is defined).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module requant_lane
  import out_buff_pkg::*;
(
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic [SHIFT_WIDTH-1:0]        shift_i,
  input  wire logic signed [IN_WIDTH-1:0]    data_i,
  input  wire logic                          s1_en_i,
  input  wire logic                          s2_en_i,
  output logic signed [OUT_WIDTH-1:0]        data_o
);

  logic signed [IN_WIDTH:0]  ext_w;
  logic signed [IN_WIDTH:0]  bias_w;
  logic signed [IN_WIDTH:0]  s1_d;
  logic signed [IN_WIDTH:0]  s1_q;
  logic signed [OUT_WIDTH-1:0] s2_d;
  logic signed [OUT_WIDTH-1:0] s2_q;

  // One extra bit keeps the rounding bias from overflowing the full-scale input.
  always_comb begin
    ext_w  = {data_i[IN_WIDTH-1], data_i};
    bias_w = '0;
    if (shift_i != '0) begin
      bias_w = (IN_WIDTH+1)'(1) << (shift_i - 1'b1);
    end
    s1_d = (ext_w + bias_w) >>> shift_i;
  end

  always_comb begin
`ifdef OUT_REQUANT_RELU_EN
    s2_d = s1_q[IN_WIDTH] ? '0 : sat_out(s1_q);
`else
    s2_d = sat_out(s1_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (s1_en_i) s1_q <= s1_d;
      if (s2_en_i) s2_q <= s2_d;
    end
  end

  assign data_o = s2_q;

endmodule

`default_nettype wire

// File: rtl/out_requant_writer.sv
//------------------------------------------------------------------------------
// Module  : out_requant_writer
// Brief   : Requantizes PE-array even/odd column sums and writes them into the
//           double output buffer; tile FSM, beat counter and address in here.
//           Optional macro: OUT_REQUANT_RELU_EN (clamp negatives to zero).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module out_requant_writer
  import out_buff_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  out_requant_writer_if.slave bus
);

  orw_state_t             state_q;
  tile_cfg_t              cfg_q;
  logic [LEN_WIDTH-1:0]   beat_cnt_q;
  logic                   busy_q;
  logic                   tile_done_q;
  logic                   err_drop_q;

  logic                   s1_v_q;
  logic [ADDR_WIDTH-1:0]  s1_addr_q;
  logic [ADDR_WIDTH-1:0]  waddr_q;
  logic [NUM_PE_ROW-1:0]  wen_q;

  logic                   accept_w;
  logic                   drop_w;
  logic                   start_ok_w;
  logic                   last_beat_w;

  logic signed [OUT_WIDTH-1:0] even_w [NUM_PE_ROW];
  logic signed [OUT_WIDTH-1:0] odd_w  [NUM_PE_ROW];

  assign start_ok_w  = bus.start_i && (state_q == IDLE);
  assign accept_w    = bus.array_valid_i && (state_q == RUN);
  assign drop_w      = bus.array_valid_i && (state_q != RUN);
  assign last_beat_w = accept_w && (beat_cnt_q == cfg_q.tile_len - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      if (drop_w)          err_drop_q <= 1'b1;
      else if (start_ok_w) err_drop_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            cfg_q      <= '{base_addr: bus.base_addr_i, tile_len: bus.tile_len_i,
                            shift_amt: bus.shift_amt_i, row_en: bus.row_en_i};
            beat_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= (bus.tile_len_i == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept_w) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_beat_w) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // S1 empty now means both stages are empty next cycle (no accepts here).
          if (!s1_v_q) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_addr_q <= '0;
      wen_q     <= '0;
      waddr_q   <= '0;
    end else begin
      s1_v_q <= accept_w;
      if (accept_w) s1_addr_q <= cfg_q.base_addr + beat_cnt_q[ADDR_WIDTH-1:0];
      wen_q  <= {NUM_PE_ROW{s1_v_q}} & cfg_q.row_en;
      if (s1_v_q)   waddr_q   <= s1_addr_q;
    end
  end

  for (genvar r = 0; r < NUM_PE_ROW; r++) begin : g_row
    requant_lane u_even (
      .clk     (clk),
      .rst     (rst),
      .shift_i (cfg_q.shift_amt),
      .data_i  (bus.array_out_even_i[r*IN_WIDTH +: IN_WIDTH]),
      .s1_en_i (accept_w),
      .s2_en_i (s1_v_q && cfg_q.row_en[r]),
      .data_o  (even_w[r])
    );
    requant_lane u_odd (
      .clk     (clk),
      .rst     (rst),
      .shift_i (cfg_q.shift_amt),
      .data_i  (bus.array_out_odd_i[r*IN_WIDTH +: IN_WIDTH]),
      .s1_en_i (accept_w),
      .s2_en_i (s1_v_q && cfg_q.row_en[r]),
      .data_o  (odd_w[r])
    );
  end

  always_comb begin
    bus.wdata_even_o = '0;
    bus.wdata_odd_o  = '0;
    for (int r = 0; r < NUM_PE_ROW; r++) begin
      bus.wdata_even_o[r*OUT_WIDTH +: OUT_WIDTH] = even_w[r];
      bus.wdata_odd_o[r*OUT_WIDTH +: OUT_WIDTH]  = odd_w[r];
    end
  end

  assign bus.wen_even_AH_o = wen_q;
  assign bus.wen_odd_AH_o  = wen_q;
  assign bus.waddr_o       = {NUM_PE_ROW{waddr_q}};
  assign bus.busy_o        = busy_q;
  assign bus.tile_done_o   = tile_done_q;
  assign bus.err_drop_o    = err_drop_q;

endmodule

`default_nettype wire
